// File: rtl/sd_to_binary_converter.sv
// Signed-digit to two's-complement converter, one digit per cycle MSD first,
// using on-the-fly Q/QM conversion (concatenation only, no carry-propagate adder).
module sd_to_binary_converter #(
    parameter int no_of_digits = 4,
    parameter int radix_bits   = 3
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic [no_of_digits*radix_bits-1:0]         sd_vec,
    input  logic                                       in_valid,
    output logic                                       in_ready,
    output logic [no_of_digits*(radix_bits-1):0]       result,
    output logic                                       out_valid,
    input  logic                                       out_ready,
    output logic                                       err
);

    localparam int B  = radix_bits - 1;
    localparam int W  = no_of_digits * B + 1;
    localparam int VW = no_of_digits * radix_bits;
    localparam int CW = $clog2(no_of_digits + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        HOLD    = 2'd2
    } state_t;

    state_t                state_r;
    logic [VW-1:0]         shreg_r;
    logic [W-1:0]          q_r;
    logic [W-1:0]          qm_r;
    logic [CW-1:0]         cnt_r;
    logic                  err_acc_r;
    logic [W-1:0]          result_r;
    logic                  err_r;
    logic                  in_ready_r;
    logic                  out_valid_r;

    logic [radix_bits-1:0] digit_s;
    logic                  digit_neg_s;
    logic                  digit_pos_s;
    logic                  digit_illegal_s;
    logic [B-1:0]          digit_lo_s;
    logic [B-1:0]          digit_m1_lo_s;
    logic [W-1:0]          q_next_s;
    logic [W-1:0]          qm_next_s;
    logic                  last_digit_s;
    logic                  err_next_s;

    // Decode the current top digit and form the next Q/QM by concatenation.
    // Adding R leaves the low b bits unchanged, so (R+d) and (R-1+d) reduce to d and d-1.
    always_comb begin
        digit_s         = shreg_r[VW-1 -: radix_bits];
        digit_neg_s     = digit_s[radix_bits-1];
        digit_lo_s      = digit_s[B-1:0];
        digit_m1_lo_s   = digit_lo_s - B'(1);
        digit_illegal_s = (digit_s == {1'b1, {B{1'b0}}});
        digit_pos_s     = 1'b0;
        if (!digit_neg_s && (digit_lo_s != {B{1'b0}})) begin
            digit_pos_s = 1'b1;
        end else begin
            digit_pos_s = 1'b0;
        end

        q_next_s = {q_r[W-1-B:0], digit_lo_s};
        if (digit_neg_s) begin
            q_next_s = {qm_r[W-1-B:0], digit_lo_s};
        end else begin
            q_next_s = {q_r[W-1-B:0], digit_lo_s};
        end

        qm_next_s = {qm_r[W-1-B:0], digit_m1_lo_s};
        if (digit_pos_s) begin
            qm_next_s = {q_r[W-1-B:0], digit_m1_lo_s};
        end else begin
            qm_next_s = {qm_r[W-1-B:0], digit_m1_lo_s};
        end

        last_digit_s = (cnt_r == CW'(no_of_digits - 1));
        err_next_s   = err_acc_r | digit_illegal_s;
    end

    // Control FSM with datapath registers and registered handshake/result outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            shreg_r     <= '0;
            q_r         <= '0;
            qm_r        <= '1;
            cnt_r       <= '0;
            err_acc_r   <= 1'b0;
            result_r    <= '0;
            err_r       <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        shreg_r    <= sd_vec;
                        q_r        <= '0;
                        qm_r       <= '1;
                        cnt_r      <= '0;
                        err_acc_r  <= 1'b0;
                        in_ready_r <= 1'b0;
                        state_r    <= CONVERT;
                    end
                end
                CONVERT: begin
                    shreg_r   <= shreg_r << radix_bits;
                    q_r       <= q_next_s;
                    qm_r      <= qm_next_s;
                    cnt_r     <= cnt_r + CW'(1);
                    err_acc_r <= err_next_s;
                    if (last_digit_s) begin
                        // A vector with any illegal digit reports zero rather than a wrapped value.
                        result_r    <= err_next_s ? '0 : q_next_s;
                        err_r       <= err_next_s;
                        out_valid_r <= 1'b1;
                        state_r     <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign err       = err_r;

endmodule

// File: doc/sd_to_binary_converter.md
# sd_to_binary_converter

Sequential converter that sits directly downstream of the signed-digit shift/collect stage. It accepts one packed vector of `no_of_digits` radix-2^(radix_bits-1) signed digits and resolves it, one digit per cycle and most significant digit first, into a two's-complement integer. It uses on-the-fly conversion: Q/QM register pairs with concatenation only, and no carry-propagate adder. Input and output both use a valid/ready handshake.

## Interface
- `no_of_digits`, 4, number of digits per vector (>=2)
- `radix_bits`, 3, bits per signed digit; radix R = 2^(radix_bits-1), b = radix_bits-1
- Derived W = no_of_digits*b + 1, result width
- `clk`  input  1  rising-edge clock
- `reset`  input  1  asynchronous, active-low reset; clears all state immediately
- `sd_vec`  input  no_of_digits*radix_bits  packed digits; digit 0 (MSD) in top field, last digit (LSD) in bits [radix_bits-1:0]; each field is two's complement
- `in_valid`  input  1  `sd_vec` valid
- `in_ready`  output  1  block can accept a vector
- `result`  output  W  signed two's-complement value, sum d_i*R^(no_of_digits-1-i)
- `out_valid`  output  1  `result`/`err` valid
- `out_ready`  input  1  consumer takes the result
- `err`  output  1  vector contained an illegal digit code

## Operation
- Legal digit range is [-(R-1), R-1]. Code -R (fields `100..0`) is illegal.
- FSM has three states: IDLE, CONVERT, HOLD.
  - `in_ready` = (state==IDLE).
  - `out_valid` = (state==HOLD).
- IDLE: on `in_valid && in_ready` the block:
  - latches `sd_vec` into a shift register;
  - sets Q=0 and QM=all ones (-1), both W bits;
  - sets the digit counter to 0 and clears the error accumulator;
  - moves to CONVERT.
- CONVERT: each cycle takes the top digit d of the shift register, then shifts the register left by radix_bits and increments the counter.
  - Q update: d>=0 gives Q<={Q[W-1-b:0], d[b-1:0]}; d<0 gives Q<={QM[W-1-b:0], (R+d)[b-1:0]}.
  - QM update: d>0 gives QM<={Q[W-1-b:0], (d-1)[b-1:0]}; d<=0 gives QM<={QM[W-1-b:0], (R-1+d)[b-1:0]}.
  - Invariant: QM == Q-1 after every step.
  - If d == -R, the error accumulator is set and Q/QM still update using the d<0 / d<=0 rules; only the low b bits are kept.
  - After the no_of_digits-th digit the FSM moves to HOLD.
- HOLD: `result`=Q and `err`=error accumulator, both held stable.
  - If `err`=1, `result` is forced to 0.
  - On `out_ready` the FSM returns to IDLE.
- `in_valid` while not in IDLE is ignored. `sd_vec` is sampled only at acceptance.
- Reset values: state=IDLE, `in_ready`=1, `out_valid`=0, `result`=0, `err`=0, Q=0, QM=-1, counter=0.

## Timing
- Vector accepted at edge k; digit i is processed at edge k+1+i.
- `out_valid` rises after edge k+no_of_digits and stays high until the edge where `out_ready`=1.
- `in_ready` rises in the cycle after the handshake edge. There is no overlap: throughput is one vector per no_of_digits+2 cycles minimum.
- If `out_ready` is already high when HOLD is entered, HOLD lasts exactly one cycle.
- `result`/`err` change only on entry to HOLD and must not glitch while `out_valid`=1. Outside HOLD, `result` holds its last value (0 after reset).
- Reset asserted mid-CONVERT or mid-HOLD:
  - all outputs go to their reset values asynchronously;
  - the partial conversion is discarded;
  - there is no output for that vector.
- Reset release is synchronous to `clk` at the bench level. The first acceptance can occur at the first edge after release.

## Test plan
- Default params, digits [1,-2,3,-1], `sd_vec`=12'h39F, `out_ready`=1 → `out_valid` after 4 edges, `result`=9'h02B (43), `err`=0, one-cycle HOLD.
- Digits [-1,0,0,1], `sd_vec`=12'hE01 → `result`=9'h1C1 (-63). Digits [3,3,3,3], 12'h6DB → 9'h0FF. Digits [-3,-3,-3,-3], 12'hB6D → 9'h101. All-zero → 0.
- Digit -4 present (`sd_vec`=12'h800) → `err`=1, `result`=0. The next legal vector gives `err`=0.
- Back-pressure: hold `out_ready`=0 for 5 cycles with `in_valid` held high and a new vector presented → `result` stays stable, `in_ready`=0, second vector accepted only in the cycle after the HOLD handshake.
- Assert `reset` low during the 2nd CONVERT cycle → `out_valid`=0, `in_ready`=1 immediately. After release, a fresh vector converts correctly with no residue.
- Randomised legal vectors with random `in_valid`/`out_ready` stalls → `result` matches the reference sum for every vector, with exactly one output per accepted input.
